alu_seq_ctrl: RTL
=================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 20: datapath word width in bits.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  requester presents an operation.
REQ-005 req_ready  output  1  controller can accept an operation.
REQ-006 req_op  input  4  opcode: 0 NOT, 1 AND, 2 OR, 3 XOR, 4 SHR, 5 SHL, 6 ROR, 7 ROL, 8 INC, 9 DEC, A ADD, B ADC, C SUB, D SBC, E CMP, F SWAP.
REQ-007 req_mode  input  1  1 = full-word, 0 = half-word.
REQ-008 req_a  input  WIDTH  operand A.
REQ-009 req_b  input  WIDTH  operand B; ignored by unary ops.
REQ-010 rsp_valid  output  1  result beat available.
REQ-011 rsp_ready  input  1  consumer accepts the beat.
REQ-012 rsp_data  output  WIDTH  result beat.
REQ-013 rsp_last  output  1  final beat of the operation.
REQ-014 status  output  3  {C,S,Z} status register.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, EXEC, RSP1, RSP2; req_ready = (state==IDLE).
REQ-017 IDLE: on req_valid&&req_ready, latch op/mode/a/b and go to EXEC; otherwise stay in IDLE.
REQ-018 EXEC lasts exactly one cycle: compute the result into a register, update status, then go to RSP1; CMP goes directly to IDLE with no beat.
REQ-019 Latency: if accepted at edge N, rsp_valid is high from edge N+2; status is updated at edge N+2.
REQ-020 RSP1/RSP2: rsp_valid=1; rsp_data and rsp_last are held stable until rsp_valid&&rsp_ready.
REQ-021 SWAP: RSP1 beat = B with rsp_last=0, then RSP2 beat = A with rsp_last=1; all other ops: RSP1 only, rsp_last=1.
REQ-022 After the final beat handshake, return to IDLE; req_ready rises the next cycle (no accept in the same cycle as the final beat).
REQ-023 Z = (result==0) within the active width; S = active MSB of result.
REQ-024 C rules: ADD/ADC/INC set C = carry-out; SUB/SBC/DEC/CMP set C = borrow (unsigned A<B); SHR sets C = a[0]; SHL sets C = active MSB of a.
REQ-025 Logic ops (NOT, AND, OR, XOR) clear C; ROR, ROL and SWAP leave C unchanged.
REQ-026 ADC = A+B+C; SBC = A-B-C, using C as held at the start of EXEC.
REQ-027 CMP computes A-B for flags only.
REQ-028 SWAP leaves status unchanged.
REQ-029 Arithmetic wraps modulo 2^active width.
REQ-030 rsp_valid=0 in IDLE and EXEC.

Reset
REQ-031 rst_n low immediately forces state to IDLE, rsp_valid=0, rsp_data=0, rsp_last=0, status=000, busy=0, req_ready=1, from any state.
REQ-032 An operation interrupted by reset is discarded and produces no beat.

Configuration
REQ-033 Macro ALU_SEQ_HALFWORD_EN defined: req_mode=0 operates on bits [WIDTH/2-1:0].
- Upper result bits are forced to 0.
- S, Z and C are taken at bit WIDTH/2-1 / bit WIDTH/2.
REQ-034 Macro ALU_SEQ_HALFWORD_EN undefined: req_mode is ignored and every op is full-word.

Verification
REQ-035 ADD a=0xFFFFF b=0x00001 mode=1 -> rsp_data=0x00000, status C=1,S=0,Z=1, rsp_valid at accept+2.
REQ-036 Then ADC a=0x00010 b=0x00001 -> rsp_data=0x00012, status=000.
REQ-037 SWAP a=0x12345 b=0x0ABCD, rsp_ready low 3 cycles -> beat 0x0ABCD last=0 held stable, then beat 0x12345 last=1; status unchanged.
REQ-038 CMP a=5 b=5 -> no rsp_valid, Z=1 C=0, req_ready high again at accept+2.
REQ-039 AND a=0xFFFFF b=0x003FF mode=0 -> rsp_data=0x003FF; S=1 with ALU_SEQ_HALFWORD_EN, S=0 without.
REQ-040 rst_n low while in RSP1 -> rsp_valid=0 and status=000 without a clock edge; req_ready=1 after release.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
//   Sequential ALU controller. It accepts one operation through a
//   valid/ready request port, evaluates it in a single EXEC cycle, and
//   returns the result as one or two response beats over a valid/ready
//   port. A {C,S,Z} status register is updated as each operation executes.
//
//   Sequence: IDLE -> EXEC -> RSP1 [-> RSP2] -> IDLE
//     - CMP returns from EXEC straight to IDLE and produces no beat.
//     - SWAP returns B in RSP1, then A in RSP2.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  request valid          req_ready  controller idle
//   req_op     opcode (4 bits)        req_mode   1 = full word, 0 = half word
//   req_a      operand A              req_b      operand B
//   rsp_valid  response beat valid    rsp_ready  consumer accepts the beat
//   rsp_data   response beat          rsp_last   final beat of the operation
//   status     {C,S,Z}                busy       any state other than IDLE
//
// Configuration
//   ALU_SEQ_HALFWORD_EN  when defined, req_mode=0 restricts the operation
//                        to bits [WIDTH/2-1:0]; when undefined every
//                        operation is full word.
// ---------------------------------------------------------------------------
module alu_seq_ctrl #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic             req_mode,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_last,
  output logic [2:0]       status,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RSP1, RSP2} state_e;

  typedef enum logic [3:0] {
    OP_NOT, OP_AND, OP_OR,  OP_XOR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
    OP_INC, OP_DEC, OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP, OP_SWAP
  } op_e;

  localparam int HW = WIDTH / 2;
  localparam logic [WIDTH-1:0] LO_MASK = {{(WIDTH-HW){1'b0}}, {HW{1'b1}}};

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [2:0]       status_q, status_d;

  logic             halfSel;
  logic [WIDTH-1:0] opA, opB, aluRes;
  logic [WIDTH:0]   raw;
  logic             carryBit, newC, sFlag, zFlag;

  // Half-word operation only exists in the configured build; otherwise the
  // latched mode bit is deliberately masked off.
`ifdef ALU_SEQ_HALFWORD_EN
  assign halfSel = ~mode_q;
`else
  assign halfSel = 1'b0 & ~mode_q;
`endif

  // ALU datapath. Operands are masked to the active width first, so the
  // extra bit at position HW (half) or WIDTH (full) is the carry/borrow.
  always_comb begin
    opA  = halfSel ? (a_q & LO_MASK) : a_q;
    opB  = halfSel ? (b_q & LO_MASK) : b_q;
    raw  = '0;
    newC = status_q[2];
    unique case (op_q)
      OP_NOT:  raw = {1'b0, ~opA};
      OP_AND:  raw = {1'b0, opA & opB};
      OP_OR:   raw = {1'b0, opA | opB};
      OP_XOR:  raw = {1'b0, opA ^ opB};
      OP_SHR:  raw = {1'b0, opA >> 1};
      OP_SHL:  raw = {1'b0, opA << 1};
      OP_ROR:  raw = halfSel ? {1'b0, (opA >> 1) | ({{(WIDTH-1){1'b0}}, opA[0]} << (HW-1))}
                             : {1'b0, opA[0], opA[WIDTH-1:1]};
      OP_ROL:  raw = halfSel ? {1'b0, (opA << 1) | {{(WIDTH-1){1'b0}}, opA[HW-1]}}
                             : {1'b0, opA[WIDTH-2:0], opA[WIDTH-1]};
      OP_INC:  raw = {1'b0, opA} + {{WIDTH{1'b0}}, 1'b1};
      OP_DEC:  raw = {1'b0, opA} - {{WIDTH{1'b0}}, 1'b1};
      OP_ADD:  raw = {1'b0, opA} + {1'b0, opB};
      OP_ADC:  raw = {1'b0, opA} + {1'b0, opB} + {{WIDTH{1'b0}}, status_q[2]};
      OP_SUB,
      OP_CMP:  raw = {1'b0, opA} - {1'b0, opB};
      OP_SBC:  raw = {1'b0, opA} - {1'b0, opB} - {{WIDTH{1'b0}}, status_q[2]};
      OP_SWAP: raw = {1'b0, opB};
      default: raw = '0;
    endcase

    aluRes   = halfSel ? (raw[WIDTH-1:0] & LO_MASK) : raw[WIDTH-1:0];
    carryBit = halfSel ? raw[HW] : raw[WIDTH];
    sFlag    = halfSel ? aluRes[HW-1] : aluRes[WIDTH-1];
    zFlag    = (aluRes == '0);

    unique case (op_q)
      OP_NOT, OP_AND, OP_OR, OP_XOR: newC = 1'b0;
      OP_SHR:                        newC = opA[0];
      OP_SHL:                        newC = halfSel ? opA[HW-1] : opA[WIDTH-1];
      OP_ROR, OP_ROL, OP_SWAP:       newC = status_q[2];
      default:                       newC = carryBit;
    endcase
  end

  // State register and operand/result/status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_NOT;
      mode_q   <= 1'b1;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      status_q <= 3'b000;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mode_q   <= mode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      status_q <= status_d;
    end
  end

  // Next-state logic. SWAP keeps A latched so RSP2 can return it after B.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mode_d   = mode_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    status_d = status_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = op_e'(req_op);
          mode_d  = req_mode;
          a_d     = req_a;
          b_d     = req_b;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (op_q != OP_SWAP) begin
          status_d = {newC, sFlag, zFlag};
        end
        if (op_q == OP_CMP) begin
          state_d = IDLE;
        end else begin
          res_d   = aluRes;
          state_d = RSP1;
        end
      end
      RSP1: begin
        if (rsp_ready) begin
          if (op_q == OP_SWAP) begin
            res_d   = opA;
            state_d = RSP2;
          end else begin
            state_d = IDLE;
          end
        end
      end
      RSP2: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RSP1) || (state_q == RSP2);
  assign rsp_last  = (state_q == RSP2) || ((state_q == RSP1) && (op_q != OP_SWAP));
  assign rsp_data  = res_q;
  assign status    = status_q;

endmodule
